// File: rtl/dae_pkg.sv
// Shared encodings for the decode-and-execute front-end: FSM states,
// seven-segment glyph table and digit-enable patterns.
// Latency: n/a (constants only). Backpressure: n/a.
package dae_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_EXEC = 3'd2,
    ST_HOLD = 3'd3,
    ST_RUN  = 3'd4
  } dae_state_t;

  // Active-low segments, bit 0 = a ... bit 6 = g.
  localparam logic [6:0] HEX2SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,  // 0 1 2 3
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,  // 4 5 6 7
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,  // 8 9 A b
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110   // C d E F
  };

  // Active-low one-hot digit enables, index = digit number.
  localparam logic [3:0] AN_DIGIT [4] = '{
    4'b1110, 4'b1101, 4'b1011, 4'b0111
  };

endpackage

// File: rtl/dae_seg_scan.sv
// Four-digit seven-segment scanner: free-running refresh counter picks a
// nibble, decodes it to hex glyph. Latency: an/seg 1 clk after digit select.
// Backpressure: none; free-running.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   nib0..nib3  [3:0] values shown on digits 0..3
//   an          [3:0] digit enables, active-low one-hot
//   seg         [6:0] segments, active-low, seg[0]=a
module dae_seg_scan
  import dae_pkg::*;
#(
  parameter int REFRESH_W = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] nib0,
  input  logic [3:0] nib1,
  input  logic [3:0] nib2,
  input  logic [3:0] nib3,
  output logic [3:0] an,
  output logic [6:0] seg
);

  logic [REFRESH_W-1:0] refresh_cnt;
  logic [1:0]           digit;
  logic [3:0]           nib;

  assign digit = refresh_cnt[REFRESH_W-1 -: 2];

  always_comb begin
    nib = nib0;
    case (digit)
      2'd0:    nib = nib0;
      2'd1:    nib = nib1;
      2'd2:    nib = nib2;
      default: nib = nib3;
    endcase
  end

  // an and seg update on the same edge so a digit never shows its
  // neighbour's glyph.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
      an          <= AN_DIGIT[0];
      seg         <= HEX2SEG[0];
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
      an          <= AN_DIGIT[digit];
      seg         <= HEX2SEG[nib];
    end
  end

endmodule

// File: rtl/dae_ctrl_scan.sv
// Sequencer/display front-end for the combinational decode-and-execute unit.
// Latency: press -> operands driven 4 clks, result captured EXEC_CYCLES later.
// Backpressure: none; button presses arriving while busy are dropped.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   sw_rs/sw_rt [3:0], sw_sel [2:0]  operand/opcode switches (sampled on load)
//   btn_load, btn_run          debounced buttons, asynchronous
//   dae_rs/dae_rt [3:0], dae_sel [2:0]  drive to the unit
//   dae_rd [3:0]               combinational result from the unit
//   busy, running              status (LOAD/EXEC, RUN)
//   an [3:0], seg [6:0]        active-low display
module dae_ctrl_scan
  import dae_pkg::*;
#(
  parameter int REFRESH_W   = 17,
  parameter int STEP_CYCLES = 50_000_000,
  parameter int EXEC_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw_rs,
  input  logic [3:0] sw_rt,
  input  logic [2:0] sw_sel,
  input  logic       btn_load,
  input  logic       btn_run,
  output logic [3:0] dae_rs,
  output logic [3:0] dae_rt,
  output logic [2:0] dae_sel,
  input  logic [3:0] dae_rd,
  output logic       busy,
  output logic       running,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int EXEC_W = $clog2(EXEC_CYCLES + 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
  localparam logic [EXEC_W-1:0] EXEC_LAST = EXEC_W'(EXEC_CYCLES - 1);

  dae_state_t        state, state_nxt;
  logic [2:0]        load_sync, run_sync;   // [1:0] synchroniser, [2] previous
  logic              load_p, run_p;
  logic [EXEC_W-1:0] exec_cnt;
  logic [STEP_W-1:0] step_cnt;
  logic [3:0]        result;
  logic              exec_done, step_tick, enter_load;

  // Two flops of synchronisation plus a registered rising-edge detect:
  // a press shows up as a one-clock pulse three clocks later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_sync <= '0;
      run_sync  <= '0;
      load_p    <= 1'b0;
      run_p     <= 1'b0;
    end else begin
      load_sync <= {load_sync[1:0], btn_load};
      run_sync  <= {run_sync[1:0], btn_run};
      load_p    <= load_sync[1] & ~load_sync[2];
      run_p     <= run_sync[1] & ~run_sync[2];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_HOLD: begin
        if (load_p)     state_nxt = ST_LOAD;   // load beats run on a tie
        else if (run_p) state_nxt = ST_RUN;
      end
      ST_LOAD: state_nxt = ST_EXEC;
      ST_EXEC: if (exec_cnt == EXEC_LAST) state_nxt = ST_HOLD;
      ST_RUN: begin
        if (load_p)     state_nxt = ST_LOAD;
        else if (run_p) state_nxt = ST_HOLD;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign enter_load = (state_nxt == ST_LOAD);
  assign exec_done  = (state == ST_EXEC) && (exec_cnt == EXEC_LAST);
  // Leaving auto-run on the terminal count takes no final capture.
  assign step_tick  = (state == ST_RUN) && (state_nxt == ST_RUN) &&
                      (step_cnt == STEP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      running  <= 1'b0;
      exec_cnt <= '0;
      step_cnt <= '0;
    end else begin
      state    <= state_nxt;
      busy     <= (state_nxt == ST_LOAD) || (state_nxt == ST_EXEC);
      running  <= (state_nxt == ST_RUN);
      exec_cnt <= (state == ST_EXEC) ? exec_cnt + 1'b1 : '0;
      if ((state == ST_RUN) && (state_nxt == ST_RUN))
        step_cnt <= step_tick ? '0 : step_cnt + 1'b1;
      else
        step_cnt <= '0;
    end
  end

  // Operands are taken on the edge that enters LOAD, so the unit is already
  // driven during LOAD and has LOAD plus EXEC_CYCLES to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dae_rs  <= '0;
      dae_rt  <= '0;
      dae_sel <= '0;
      result  <= '0;
    end else begin
      if (enter_load) begin
        dae_rs  <= sw_rs;
        dae_rt  <= sw_rt;
        dae_sel <= sw_sel;
      end else if (step_tick) begin
        dae_sel <= dae_sel + 3'd1;
      end
      if (exec_done || step_tick)
        result <= dae_rd;
    end
  end

  dae_seg_scan #(
    .REFRESH_W (REFRESH_W)
  ) u_seg_scan (
    .clk   (clk),
    .rst_n (rst_n),
    .nib0  (result),
    .nib1  ({1'b0, dae_sel}),
    .nib2  (dae_rt),
    .nib3  (dae_rs),
    .an    (an),
    .seg   (seg)
  );

endmodule
